// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one line-wide physical-memory port between the I-cache and D-cache.
// A grant is held until pmem_resp and followed by one dead RELEASE cycle.
module pmem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LINE_W  = 256,
  parameter bit          D_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_pmem_read,
  input  logic              i_pmem_write,
  input  logic [ADDR_W-1:0] i_pmem_address,
  input  logic [LINE_W-1:0] i_pmem_wdata,
  output logic              i_pmem_resp,
  output logic [LINE_W-1:0] i_pmem_rdata,

  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [LINE_W-1:0] d_pmem_rdata,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,

  output logic              grant_d,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                grant_d_q, grant_d_d;
  logic                last_d_q, last_d_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;

  logic                req_i, req_d;
  logic                win_d;
  logic                sel_rd, sel_wr, sel_req;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LINE_W-1:0]   sel_wdata;
  logic                eff_rd, eff_wr;
  logic [ADDR_W-1:0]   eff_addr;
  logic [LINE_W-1:0]   eff_wdata;

  // State and replay registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      grant_d_q <= 1'b0;
      last_d_q  <= ~D_FIRST;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_d_q <= grant_d_d;
      last_d_q  <= last_d_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Next-state, arbitration and port muxing
  always_comb begin
    state_d      = state_q;
    grant_d_d    = grant_d_q;
    last_d_d     = last_d_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;

    req_i = i_pmem_read | i_pmem_write;
    req_d = d_pmem_read | d_pmem_write;
    win_d = (req_i && req_d) ? ~last_d_q : req_d;

    sel_rd    = grant_d_q ? d_pmem_read    : i_pmem_read;
    sel_wr    = grant_d_q ? d_pmem_write   : i_pmem_write;
    sel_addr  = grant_d_q ? d_pmem_address : i_pmem_address;
    sel_wdata = grant_d_q ? d_pmem_wdata   : i_pmem_wdata;
    sel_req   = sel_rd | sel_wr;

    // A withdrawn request is replayed so memory never sees it vanish mid-transfer
    eff_rd    = sel_req ? sel_rd    : rd_q;
    eff_wr    = sel_req ? sel_wr    : wr_q;
    eff_addr  = sel_req ? sel_addr  : addr_q;
    eff_wdata = sel_req ? sel_wdata : wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_i || req_d) begin
          state_d   = ST_BUSY;
          grant_d_d = win_d;
          last_d_d  = win_d;
          rd_d      = win_d ? d_pmem_read    : i_pmem_read;
          wr_d      = win_d ? d_pmem_write   : i_pmem_write;
          addr_d    = win_d ? d_pmem_address : i_pmem_address;
          wdata_d   = win_d ? d_pmem_wdata   : i_pmem_wdata;
        end
      end
      ST_BUSY: begin
        rd_d         = eff_rd;
        wr_d         = eff_wr;
        addr_d       = eff_addr;
        wdata_d      = eff_wdata;
        pmem_write   = eff_wr;
        pmem_read    = eff_rd & ~eff_wr;
        pmem_address = eff_addr;
        pmem_wdata   = eff_wdata;
        i_pmem_resp  = pmem_resp & ~grant_d_q;
        d_pmem_resp  = pmem_resp &  grant_d_q;
        if (pmem_resp) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign grant_d      = grant_d_q;
  assign busy         = (state_q == ST_BUSY);

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: single read, simultaneous grant, round-robin,
// write-back, request withdrawal and asynchronous reset during a transfer.
module tb_pmem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_pmem_read, i_pmem_write, i_pmem_resp;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_wdata, i_pmem_rdata;
  logic              d_pmem_read, d_pmem_write, d_pmem_resp;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata, d_pmem_rdata;
  logic              pmem_read, pmem_write, pmem_resp;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata, pmem_rdata;
  logic              grant_d, busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [LINE_W-1:0] line_a5;
  logic [LINE_W-1:0] line_rd;
  logic              exp_g;

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .D_FIRST(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_write   (i_pmem_write),
    .i_pmem_address (i_pmem_address),
    .i_pmem_wdata   (i_pmem_wdata),
    .i_pmem_resp    (i_pmem_resp),
    .i_pmem_rdata   (i_pmem_rdata),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_resp    (d_pmem_resp),
    .d_pmem_rdata   (d_pmem_rdata),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_resp      (pmem_resp),
    .pmem_rdata     (pmem_rdata),
    .grant_d        (grant_d),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input string tag, input int max_cyc);
    for (int n = 0; n < max_cyc && !busy; n++) begin
      cyc();
      #1;
    end
    chk(tag, 256'(busy), 256'(1));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    i_pmem_read = 1'b0; i_pmem_write = 1'b0; i_pmem_address = '0; i_pmem_wdata = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    line_a5 = {32{8'hA5}};
    line_rd = {8{32'h1234_5678}};

    #3;
    chk("rst_busy",    256'(busy),       256'(0));
    chk("rst_grant",   256'(grant_d),    256'(0));
    chk("rst_rd",      256'(pmem_read),  256'(0));
    chk("rst_wr",      256'(pmem_write), 256'(0));
    cyc(); cyc();
    rst = 1'b1;

    // 1: single I read, memory answers on cycle 4
    cyc();
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0060;
    #1 chk("t1_c0_rd", 256'(pmem_read), 256'(0));
    cyc(); #1;
    chk("t1_c1_rd",    256'(pmem_read),    256'(1));
    chk("t1_c1_addr",  256'(pmem_address), 256'(32'h60));
    chk("t1_c1_grant", 256'(grant_d),      256'(0));
    chk("t1_c1_busy",  256'(busy),         256'(1));
    cyc(); #1 chk("t1_c2_rd", 256'(pmem_read), 256'(1));
    cyc(); #1;
    chk("t1_c3_rd",    256'(pmem_read),   256'(1));
    chk("t1_c3_iresp", 256'(i_pmem_resp), 256'(0));
    cyc();
    pmem_resp = 1'b1; pmem_rdata = line_rd;
    #1;
    chk("t1_c4_rd",    256'(pmem_read),   256'(1));
    chk("t1_c4_iresp", 256'(i_pmem_resp), 256'(1));
    chk("t1_c4_irdat", i_pmem_rdata,      line_rd);
    chk("t1_c4_dresp", 256'(d_pmem_resp), 256'(0));
    cyc();
    pmem_resp = 1'b0; i_pmem_read = 1'b0;
    #1;
    chk("t1_c5_rd",    256'(pmem_read),   256'(0));
    chk("t1_c5_busy",  256'(busy),        256'(0));
    chk("t1_c5_iresp", 256'(i_pmem_resp), 256'(0));
    cyc();
    pmem_resp = 1'b1;
    #1;
    chk("idle_resp_i", 256'(i_pmem_resp), 256'(0));
    chk("idle_resp_d", 256'(d_pmem_resp), 256'(0));
    chk("idle_busy",   256'(busy),        256'(0));
    pmem_resp = 1'b0;

    // 2: simultaneous requests after reset, D wins first
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0100;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0200;
    cyc(); #1;
    chk("t2_grant_d", 256'(grant_d),      256'(1));
    chk("t2_addr_d",  256'(pmem_address), 256'(32'h100));
    pmem_resp = 1'b1;
    #1;
    chk("t2_dresp", 256'(d_pmem_resp), 256'(1));
    chk("t2_iresp", 256'(i_pmem_resp), 256'(0));
    cyc();
    pmem_resp = 1'b0; d_pmem_read = 1'b0;
    #1 chk("t2_release", 256'(busy), 256'(0));
    cyc(); #1 chk("t2_idle", 256'(busy), 256'(0));
    cyc(); #1;
    chk("t2_grant_i", 256'(grant_d),      256'(0));
    chk("t2_addr_i",  256'(pmem_address), 256'(32'h200));
    pmem_resp = 1'b1;
    #1 chk("t2_iresp2", 256'(i_pmem_resp), 256'(1));
    cyc();
    pmem_resp = 1'b0; i_pmem_read = 1'b0;

    // 3: both request continuously, grants alternate D,I,D,I
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0300;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0380;
    exp_g = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      wait_busy($sformatf("t3_busy%0d", k), 10);
      chk($sformatf("t3_grant%0d", k), 256'(grant_d), 256'(exp_g));
      chk($sformatf("t3_addr%0d", k), 256'(pmem_address), exp_g ? 256'(32'h300) : 256'(32'h380));
      pmem_resp = 1'b1;
      #1;
      chk($sformatf("t3_resp%0d", k), 256'(exp_g ? d_pmem_resp : i_pmem_resp), 256'(1));
      chk($sformatf("t3_noresp%0d", k), 256'(exp_g ? i_pmem_resp : d_pmem_resp), 256'(0));
      cyc();
      pmem_resp = 1'b0;
      exp_g = ~exp_g;
      #1;
    end
    d_pmem_read = 1'b0; i_pmem_read = 1'b0;

    // 4: D write-back, then I with read and write both raised
    d_pmem_write = 1'b1; d_pmem_address = 32'h0000_0400; d_pmem_wdata = line_a5;
    #1 wait_busy("t4_busy", 10);
    chk("t4_wr",    256'(pmem_write),   256'(1));
    chk("t4_rd",    256'(pmem_read),    256'(0));
    chk("t4_wdata", pmem_wdata,         line_a5);
    chk("t4_addr",  256'(pmem_address), 256'(32'h400));
    cyc(); #1;
    chk("t4_dresp_wait", 256'(d_pmem_resp), 256'(0));
    pmem_resp = 1'b1;
    #1;
    chk("t4_dresp", 256'(d_pmem_resp), 256'(1));
    chk("t4_iresp", 256'(i_pmem_resp), 256'(0));
    cyc();
    pmem_resp = 1'b0; d_pmem_write = 1'b0;
    #1;
    chk("t4_dresp_off", 256'(d_pmem_resp), 256'(0));
    chk("t4_wr_off",    256'(pmem_write),  256'(0));
    i_pmem_read = 1'b1; i_pmem_write = 1'b1; i_pmem_address = 32'h0000_0480; i_pmem_wdata = ~line_a5;
    #1 wait_busy("t4b_busy", 10);
    chk("t4b_wr",    256'(pmem_write), 256'(1));
    chk("t4b_rd",    256'(pmem_read),  256'(0));
    chk("t4b_grant", 256'(grant_d),    256'(0));
    pmem_resp = 1'b1;
    #1 chk("t4b_iresp", 256'(i_pmem_resp), 256'(1));
    cyc();
    pmem_resp = 1'b0; i_pmem_read = 1'b0; i_pmem_write = 1'b0;

    // 5: D withdraws its read after the grant; the original request is replayed
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0500;
    #1 wait_busy("t5_busy", 10);
    chk("t5_addr0", 256'(pmem_address), 256'(32'h500));
    cyc();
    d_pmem_read = 1'b0; d_pmem_address = 32'h0000_DEAD;
    #1;
    chk("t5_rd1",   256'(pmem_read),    256'(1));
    chk("t5_addr1", 256'(pmem_address), 256'(32'h500));
    chk("t5_busy1", 256'(busy),         256'(1));
    cyc(); #1;
    chk("t5_rd2",   256'(pmem_read),    256'(1));
    chk("t5_addr2", 256'(pmem_address), 256'(32'h500));
    pmem_resp = 1'b1;
    #1 chk("t5_dresp", 256'(d_pmem_resp), 256'(1));
    cyc();
    pmem_resp = 1'b0;
    #1 chk("t5_rd_off", 256'(pmem_read), 256'(0));

    // 6: asynchronous reset mid-transfer, then re-arbitration follows D_FIRST
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0600;
    #1 wait_busy("t6_busy", 10);
    chk("t6_grant", 256'(grant_d), 256'(1));
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_rd",    256'(pmem_read),  256'(0));
    chk("t6_rst_wr",    256'(pmem_write), 256'(0));
    chk("t6_rst_busy",  256'(busy),       256'(0));
    chk("t6_rst_grant", 256'(grant_d),    256'(0));
    d_pmem_read = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0700;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0780;
    #1 wait_busy("t6_rearb_busy", 10);
    chk("t6_rearb_grant", 256'(grant_d),      256'(1));
    chk("t6_rearb_addr",  256'(pmem_address), 256'(32'h700));
    pmem_resp = 1'b1;
    cyc();
    pmem_resp = 1'b0; d_pmem_read = 1'b0; i_pmem_read = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
